// File: rtl/seq_comp_pkg.sv
// Shared types and constants for the sequential word comparator.
// Contents: FSM state enum, result encoding, width helper functions.
package seq_comp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Result code held between comparisons; RES_NONE only after reset/accept.
  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_EQ   = 2'd1;
  localparam logic [1:0] RES_GT   = 2'd2;
  localparam logic [1:0] RES_LT   = 2'd3;

  // Width of the pair counter output: must hold the value NP.
  function automatic int unsigned cycles_width(input int unsigned np);
    return $clog2(np) + 1;
  endfunction

  // Width of the pair index; at least one bit even when NP == 1.
  function automatic int unsigned idx_width(input int unsigned np);
    return (np > 1) ? $clog2(np) : 1;
  endfunction

endpackage

// File: rtl/pair_eq_slice.sv
// Combinational 2-bit unsigned compare cell.
// Ports: pa, pb - 2-bit operands; eq/gt/lt - one-hot relation of pa to pb.
module pair_eq_slice (
  input  logic [1:0] pa,
  input  logic [1:0] pb,
  output logic       eq,
  output logic       gt,
  output logic       lt
);

  always_comb begin
    eq = (pa == pb);
    gt = (pa >  pb);
    lt = (pa <  pb);
  end

endmodule

// File: rtl/seq_word_comp.sv
// Sequential magnitude/equality comparator: latches two WIDTH-bit operands
// on start, scans them MSB-first two bits per cycle through one shared
// pair_eq_slice, then pulses done with aeqb/agtb/altb and the pair count.
// Build option: define EARLY_EXIT_EN to finish on the first differing pair;
// otherwise every comparison scans all NP pairs.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start, a, b         - request and operands (sampled when accepted)
//   busy                - scan in progress
//   done                - one-cycle result-valid pulse
//   aeqb, agtb, altb    - comparison result, held until next accepted start
//   cycles              - pairs examined by the last comparison
module seq_word_comp
  import seq_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CW    = cycles_width(WIDTH / 2)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeqb,
  output logic             agtb,
  output logic             altb,
  output logic [CW-1:0]    cycles
);

  localparam int unsigned NP = WIDTH / 2;
  localparam int unsigned IW = idx_width(NP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic [1:0]       res_q, res_d;
  logic             diff_seen_q, diff_seen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aeqb_q, aeqb_d;
  logic             agtb_q, agtb_d;
  logic             altb_q, altb_d;

  logic [1:0]       pair_a, pair_b;
  logic             pair_eq, pair_gt, pair_lt;
  logic             last_pair;

  // Select the pair under inspection from the latched operands.
  assign pair_a = 2'(a_q >> {idx_q, 1'b0});
  assign pair_b = 2'(b_q >> {idx_q, 1'b0});

  pair_eq_slice u_slice (
    .pa (pair_a),
    .pb (pair_b),
    .eq (pair_eq),
    .gt (pair_gt),
    .lt (pair_lt)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    idx_d       = idx_q;
    cycles_d    = cycles_q;
    res_d       = res_q;
    diff_seen_d = diff_seen_q;
    last_pair   = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        cycles_d = cycles_q + CW'(1);
        // Only the first differing pair from the MSB decides the result.
        if (!pair_eq && !diff_seen_q) begin
          diff_seen_d = 1'b1;
          if (pair_gt) begin
            res_d = RES_GT;
          end else if (pair_lt) begin
            res_d = RES_LT;
          end
`ifdef EARLY_EXIT_EN
          last_pair = 1'b1;
`endif
        end
        if (idx_q == '0) begin
          last_pair = 1'b1;
        end
        if (last_pair) begin
          state_d = ST_DONE;
          if (!diff_seen_d) begin
            res_d = RES_EQ;
          end
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: begin
        // IDLE and DONE both accept a new request.
        if (start) begin
          state_d     = ST_RUN;
          a_d         = a;
          b_d         = b;
          idx_d       = IW'(NP - 1);
          cycles_d    = '0;
          res_d       = RES_NONE;
          diff_seen_d = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    aeqb_d = (res_d == RES_EQ);
    agtb_d = (res_d == RES_GT);
    altb_d = (res_d == RES_LT);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      idx_q       <= '0;
      cycles_q    <= '0;
      res_q       <= RES_NONE;
      diff_seen_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aeqb_q      <= 1'b0;
      agtb_q      <= 1'b0;
      altb_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      idx_q       <= idx_d;
      cycles_q    <= cycles_d;
      res_q       <= res_d;
      diff_seen_q <= diff_seen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aeqb_q      <= aeqb_d;
      agtb_q      <= agtb_d;
      altb_q      <= altb_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign aeqb   = aeqb_q;
  assign agtb   = agtb_q;
  assign altb   = altb_q;
  assign cycles = cycles_q;

endmodule

// File: tb/tb_seq_word_comp.sv
// Self-checking bench for seq_word_comp (WIDTH=16). A transaction-level
// model predicts busy/done/results every cycle; directed scenarios add
// hand-computed latency and result expectations.
module tb_seq_word_comp;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NP    = 8;
  localparam int unsigned CW    = 4;
`ifdef EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [15:0]   a     = '0;
  logic [15:0]   b     = '0;
  logic          busy, done, aeqb, agtb, altb;
  logic [CW-1:0] cycles;

  seq_word_comp #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .aeqb   (aeqb),
    .agtb   (agtb),
    .altb   (altb),
    .cycles (cycles)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // 1-based index from the MSB of the first differing 2-bit pair; NP if equal.
  function automatic int first_pair(input logic [15:0] x, input logic [15:0] y);
    logic [15:0] d;
    int k;
    d = x ^ y;
    k = int'(NP);
    for (int i = 15; i >= 0; i--) begin
      if (d[i]) begin
        k = int'(NP) - i / 2;
        break;
      end
    end
    return k;
  endfunction

  // Transaction-level model: remaining-cycle countdown plus arithmetic result.
  logic m_busy = 1'b0, m_done = 1'b0, m_eq = 1'b0, m_gt = 1'b0, m_lt = 1'b0;
  int   m_cycles = 0, m_rem = 0, p_lat = 0;
  logic p_eq = 1'b0, p_gt = 1'b0, p_lt = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_eq = 0; m_gt = 0; m_lt = 0; m_cycles = 0; m_rem = 0;
    end else if (!m_busy && start) begin
      p_lat  = EE ? first_pair(a, b) : int'(NP);
      p_eq   = (a == b);
      p_gt   = (a > b);
      p_lt   = (a < b);
      m_busy = 1; m_done = 0; m_eq = 0; m_gt = 0; m_lt = 0; m_cycles = 0;
      m_rem  = p_lat;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 0; m_done = 1;
        m_eq = p_eq; m_gt = p_gt; m_lt = p_lt; m_cycles = p_lat;
      end
    end else begin
      m_done = 0;
    end
  end

  // Per-cycle compare; results are only meaningful while not scanning.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      if (!m_busy) begin
        chk("aeqb", 32'(aeqb), 32'(m_eq));
        chk("agtb", 32'(agtb), 32'(m_gt));
        chk("altb", 32'(altb), 32'(m_lt));
        chk("cycles", 32'(cycles), 32'(m_cycles));
      end
    end
  end

  // Count cycles from the accepting edge until done; 0 on timeout.
  task automatic wait_done(input int first_n, input bit first_seen, output int lat);
    int n;
    bit got;
    n = first_n;
    got = first_seen;
    while (n < 40 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
    end
    lat = got ? n : 0;
  endtask

  task automatic run_cmp(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                         input int exp_lat, input logic [2:0] exp_res, input int exp_cyc);
    int lat;
    @(posedge clk); #1 a = ta; b = tb_v; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(0, 1'b0, lat);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({name, "_res"}, 32'({aeqb, agtb, altb}), 32'(exp_res));
    chk({name, "_cyc"}, 32'(cycles), 32'(exp_cyc));
  endtask

  initial begin
    int lat;
    bit seen;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;

    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res",  32'({aeqb, agtb, altb}), 32'd0);
    chk("rst_cyc",  32'(cycles), 32'd0);

    run_cmp("equal", 16'hA5A5, 16'hA5A5, 9, 3'b100, 8);
    run_cmp("msb",   16'h8000, 16'h0000, EE ? 2 : 9, 3'b010, EE ? 1 : 8);

    // Reset in the middle of a scan aborts without a done pulse.
    @(posedge clk); #1 a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_res",  32'({aeqb, agtb, altb}), 32'd0);
    chk("abort_cyc",  32'(cycles), 32'd0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    run_cmp("lsb", 16'h0001, 16'h0002, 9, 3'b001, 8);
    run_cmp("mid", 16'h0F00, 16'h0E01, EE ? 5 : 9, 3'b010, EE ? 4 : 8);

    // Start held high: ignored while busy, accepted again during done.
    @(posedge clk); #1 a = 16'h1234; b = 16'h1234; start = 1'b1;
    @(posedge clk); #1 a = 16'hFFFF;
    wait_done(0, 1'b0, lat);
    chk("hold_lat", 32'(lat), 32'd9);
    chk("hold_res", 32'({aeqb, agtb, altb}), 32'b100);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(1, done, lat);
    chk("b2b_lat", 32'(lat), EE ? 32'd2 : 32'd9);
    chk("b2b_res", 32'({aeqb, agtb, altb}), 32'b010);
    chk("b2b_cyc", 32'(cycles), EE ? 32'd1 : 32'd8);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
